// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the MSP430 instruction-word encoder.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_NONE = 2'd0,
        FMT_I    = 2'd1,
        FMT_II   = 2'd2,
        FMT_J    = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INSTR   = 2'd1,
        ST_SRC_EXT = 2'd2,
        ST_DST_EXT = 2'd3
    } enc_state_e;

    localparam logic [5:0] FMT_II_PREFIX = 6'b000100;
    localparam logic [2:0] FMT_J_PREFIX  = 3'b001;
    localparam logic [3:0] REG_SR        = 4'd2;
    localparam logic [3:0] REG_CG        = 4'd3;

    // Format 0, or a double-operand opcode that collides with FMT_II/FMT_J space.
    function automatic logic req_invalid(input logic [1:0] fmt, input logic [3:0] op);
        return (fmt == FMT_NONE) || ((fmt == FMT_I) && (op < 4'd4));
    endfunction

endpackage

// File: rtl/instr_enc_len.sv
// Combinational word-count/constant-generator analysis of one request.
// INSTR_ENC_CG_EN: compress matching immediates into constant-generator encodings.
module instr_enc_len
    import instr_enc_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic        i_bw,
    input  logic [3:0]  i_sa,
    input  logic [3:0]  i_da,
    input  logic [1:0]  i_as,
    input  logic        i_ad,
    input  logic [15:0] i_src_ext,
    output logic        o_need_src,
    output logic        o_need_dst,
    output logic        o_cg_sel,
    output logic [3:0]  o_cg_reg,
    output logic [1:0]  o_cg_as
);

    logic        w_two_op;
    logic [3:0]  w_reg;
    logic        w_imm;
`ifdef INSTR_ENC_CG_EN
    logic [15:0] w_val;
    logic        w_hit;
`else
    logic        w_unused;
    assign w_unused = ^{i_bw, i_src_ext};
`endif

    always_comb begin
        w_two_op   = (i_fmt == FMT_I) || (i_fmt == FMT_II);
        w_reg      = (i_fmt == FMT_I) ? i_sa : i_da;
        w_imm      = w_two_op && (i_as == 2'b11) && (w_reg == 4'd0);
        o_cg_sel   = 1'b0;
        o_cg_reg   = w_reg;
        o_cg_as    = i_as;
`ifdef INSTR_ENC_CG_EN
        // Byte immediates are sign-extended so 0xFF lines up with -1.
        w_val = i_bw ? {{8{i_src_ext[7]}}, i_src_ext[7:0]} : i_src_ext;
        w_hit = 1'b1;
        case (w_val)
            16'h0000: begin o_cg_reg = REG_CG; o_cg_as = 2'b00; end
            16'h0001: begin o_cg_reg = REG_CG; o_cg_as = 2'b01; end
            16'h0002: begin o_cg_reg = REG_CG; o_cg_as = 2'b10; end
            16'hFFFF: begin o_cg_reg = REG_CG; o_cg_as = 2'b11; end
            16'h0004: begin o_cg_reg = REG_SR; o_cg_as = 2'b10; end
            16'h0008: begin o_cg_reg = REG_SR; o_cg_as = 2'b11; end
            default:  w_hit = 1'b0;
        endcase
        o_cg_sel = w_imm && w_hit;
        if (!o_cg_sel) begin
            o_cg_reg = w_reg;
            o_cg_as  = i_as;
        end
`endif
        o_need_src = w_two_op && !o_cg_sel &&
                     (((i_as == 2'b01) && (w_reg != REG_CG)) || w_imm);
        o_need_dst = (i_fmt == FMT_I) && i_ad && (i_da != REG_CG);
    end

endmodule

// File: rtl/instr_enc.sv
// Serialises MSP430 instruction fields into instr word, src ext, dst ext on the MDB stream.
// Optional macro INSTR_ENC_CG_EN (see instr_enc_len) enables immediate compression.
module instr_enc
    import instr_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_format,
    input  logic [3:0]  req_op,
    input  logic        req_bw,
    input  logic [3:0]  req_sa,
    input  logic [3:0]  req_da,
    input  logic [1:0]  req_as,
    input  logic        req_ad,
    input  logic [15:0] req_src_ext,
    input  logic [15:0] req_dst_ext,
    input  logic [9:0]  req_jmp_off,
    output logic [15:0] MDB_out,
    output logic        mdb_valid,
    input  logic        mdb_ready,
    output logic [1:0]  word_idx,
    output logic        err
);

    enc_state_e  r_state;
    logic        r_need_src;
    logic        r_need_dst;
    logic [15:0] r_src_ext;
    logic [15:0] r_dst_ext;

    logic        w_need_src;
    logic        w_need_dst;
    logic        w_unused_cg_sel;
    logic [3:0]  w_reg;
    logic [1:0]  w_as;
    logic [15:0] w_instr;
    logic        w_invalid;
    logic        w_hs;
    logic        w_last;
    logic        w_acc;

    instr_enc_len u_len (
        .i_fmt      (req_format),
        .i_bw       (req_bw),
        .i_sa       (req_sa),
        .i_da       (req_da),
        .i_as       (req_as),
        .i_ad       (req_ad),
        .i_src_ext  (req_src_ext),
        .o_need_src (w_need_src),
        .o_need_dst (w_need_dst),
        .o_cg_sel   (w_unused_cg_sel),
        .o_cg_reg   (w_reg),
        .o_cg_as    (w_as)
    );

    // w_reg/w_as already carry any constant-generator substitution.
    always_comb begin
        w_instr = 16'h0000;
        case (req_format)
            FMT_I:   w_instr = {req_op, w_reg, req_ad, req_bw, w_as, req_da};
            FMT_II:  w_instr = {FMT_II_PREFIX, req_op[2:0], req_bw, w_as, w_reg};
            FMT_J:   w_instr = {FMT_J_PREFIX, req_op[2:0], req_jmp_off};
            default: w_instr = 16'h0000;
        endcase
    end

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            ST_INSTR:   w_last = !r_need_src && !r_need_dst;
            ST_SRC_EXT: w_last = !r_need_dst;
            ST_DST_EXT: w_last = 1'b1;
            default:    w_last = 1'b0;
        endcase
    end

    assign w_invalid = req_invalid(req_format, req_op);
    assign w_hs      = mdb_valid && mdb_ready;
    assign req_ready = !rst && ((r_state == ST_IDLE) || (w_hs && w_last));
    assign w_acc     = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_src_ext <= req_src_ext;
            r_dst_ext <= req_dst_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_need_src <= 1'b0;
            r_need_dst <= 1'b0;
            MDB_out    <= 16'h0000;
            mdb_valid  <= 1'b0;
            word_idx   <= 2'd0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (w_acc && w_invalid) begin
                err       <= 1'b1;
                r_state   <= ST_IDLE;
                mdb_valid <= 1'b0;
                word_idx  <= 2'd0;
            end else if (w_acc) begin
                r_state    <= ST_INSTR;
                r_need_src <= w_need_src;
                r_need_dst <= w_need_dst;
                MDB_out    <= w_instr;
                mdb_valid  <= 1'b1;
                word_idx   <= 2'd0;
            end else if (w_hs) begin
                if ((r_state == ST_INSTR) && r_need_src) begin
                    r_state  <= ST_SRC_EXT;
                    MDB_out  <= r_src_ext;
                    word_idx <= 2'd1;
                end else if ((r_state != ST_DST_EXT) && r_need_dst) begin
                    r_state  <= ST_DST_EXT;
                    MDB_out  <= r_dst_ext;
                    word_idx <= 2'd2;
                end else begin
                    r_state   <= ST_IDLE;
                    mdb_valid <= 1'b0;
                    word_idx  <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed vector table, handshake corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_instr_enc;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic        bw;
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [1:0]  asm;
        logic        ad;
        logic [15:0] src;
        logic [15:0] dst;
        logic [9:0]  off;
    } req_t;

    typedef struct packed {
        logic [15:0] w;
        logic [1:0]  idx;
    } exp_t;

    typedef struct {
        req_t        r;
        int          n;
        logic [15:0] w0, w1, w2;
        logic [1:0]  i1, i2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        mdb_ready = 1'b1;
    req_t        cur = '0;
    logic        req_ready;
    logic [15:0] MDB_out;
    logic        mdb_valid;
    logic [1:0]  word_idx;
    logic        err;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t expq[$];
    bit   exp_err = 1'b0;
    bit   auto_push = 1'b0;
    bit   rnd_rdy = 1'b0;
    bit   last_acc = 1'b0;

    always #5 clk = ~clk;

    instr_enc dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_format  (cur.fmt),
        .req_op      (cur.op),
        .req_bw      (cur.bw),
        .req_sa      (cur.sa),
        .req_da      (cur.da),
        .req_as      (cur.asm),
        .req_ad      (cur.ad),
        .req_src_ext (cur.src),
        .req_dst_ext (cur.dst),
        .req_jmp_off (cur.off),
        .MDB_out     (MDB_out),
        .mdb_valid   (mdb_valid),
        .mdb_ready   (mdb_ready),
        .word_idx    (word_idx),
        .err         (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input int fmt, op, bw, sa, da, asm, ad, src, dst, off);
        req_t r;
        r.fmt = 2'(fmt);  r.op = 4'(op);   r.bw = 1'(bw);
        r.sa  = 4'(sa);   r.da = 4'(da);   r.asm = 2'(asm);
        r.ad  = 1'(ad);   r.src = 16'(src); r.dst = 16'(dst);
        r.off = 10'(off);
        return r;
    endfunction

    function automatic bit is_invalid(input req_t r);
        return (r.fmt == 2'd0) || (r.fmt == 2'd1 && int'(r.op) < 4);
    endfunction

    function automatic void push_exp(input int w, input int idx);
        exp_t e;
        e.w = 16'(w);
        e.idx = 2'(idx);
        expq.push_back(e);
    endfunction

    // Reference: derive the emitted word list straight from the ISA field rules.
    function automatic void model_push(input req_t r);
        int rg, am, w, v;
        bit imm, xs, xd;
        if (is_invalid(r)) return;
        rg  = (r.fmt == 2'd1) ? int'(r.sa) : int'(r.da);
        am  = int'(r.asm);
        imm = (r.fmt != 2'd3) && am == 3 && rg == 0;
        xs  = (r.fmt != 2'd3) && ((am == 1 && rg != 3) || imm);
        xd  = (r.fmt == 2'd1) && r.ad && int'(r.da) != 3;
`ifdef INSTR_ENC_CG_EN
        if (imm) begin
            v = r.bw ? int'(r.src) % 256 : int'(r.src);
            if (v == 0)                        begin rg = 3; am = 0; xs = 0; end
            else if (v == 1)                   begin rg = 3; am = 1; xs = 0; end
            else if (v == 2)                   begin rg = 3; am = 2; xs = 0; end
            else if (v == (r.bw ? 255 : 65535)) begin rg = 3; am = 3; xs = 0; end
            else if (v == 4)                   begin rg = 2; am = 2; xs = 0; end
            else if (v == 8)                   begin rg = 2; am = 3; xs = 0; end
        end
`else
        v = 0;
`endif
        if (r.fmt == 2'd1)
            w = int'(r.op) * 4096 + rg * 256 + int'(r.ad) * 128 + int'(r.bw) * 64 + am * 16 + int'(r.da);
        else if (r.fmt == 2'd2)
            w = 4096 + (int'(r.op) % 8) * 128 + int'(r.bw) * 64 + am * 16 + rg;
        else
            w = 8192 + (int'(r.op) % 8) * 1024 + int'(r.off);
        push_exp(w, 0);
        if (xs) push_exp(int'(r.src), 1);
        if (xd) push_exp(int'(r.dst), 2);
    endfunction

    // One clock: observe handshakes at negedge, then return 1ns after the next posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = req_valid && req_ready;
        if (mdb_valid === 1'b1 && mdb_ready) begin
            if (expq.size() == 0) chk("extra_word", 32'(MDB_out), 32'hFFFF_FFFF);
            else begin
                e = expq.pop_front();
                chk("mdb_word", {14'd0, word_idx, MDB_out}, {14'd0, e.idx, e.w});
            end
        end
        if (exp_err || err === 1'b1) chk("err_pulse", 32'(err), 32'(exp_err));
        exp_err = last_acc && is_invalid(cur);
        if (auto_push && last_acc) model_push(cur);
        @(posedge clk);
        #1;
        if (rnd_rdy) mdb_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input req_t r, input bit chk_lat, output int cyc);
        cur = r;
        req_valid = 1'b1;
        cyc = 0;
        last_acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (last_acc) break;
        end
        req_valid = 1'b0;
        if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
        else if (chk_lat) begin
            chk("latency_valid", 32'(mdb_valid), 32'd1);
            chk("latency_idx", 32'(word_idx), 32'd0);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (expq.size() == 0 && mdb_valid === 1'b0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) chk("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    function automatic req_t rnd_req();
        req_t r;
        int k;
        r.fmt = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        r.op  = 4'($urandom);
        if (r.fmt == 2'd1 && $urandom_range(0, 7) != 0) r.op = 4'($urandom_range(4, 15));
        r.bw  = 1'($urandom);
        r.sa  = 4'($urandom);
        r.da  = 4'($urandom);
        r.asm = 2'($urandom);
        r.ad  = 1'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            r.asm = 2'd3;
            if (r.fmt == 2'd1) r.sa = 4'd0; else r.da = 4'd0;
        end
        k = int'($urandom_range(0, 11));
        case (k)
            0: r.src = 16'h0000;  1: r.src = 16'h0001;  2: r.src = 16'h0002;
            3: r.src = 16'hFFFF;  4: r.src = 16'h0004;  5: r.src = 16'h0008;
            6: r.src = 16'h00FF;  default: r.src = 16'($urandom);
        endcase
        r.dst = 16'($urandom);
        r.off = 10'($urandom);
        return r;
    endfunction

    vec_t tab[13];

    initial begin
        int c;
        tab[0]  = '{mk(1,4,0,4,5,0,0,'h1111,'h2222,0),    1, 16'h4405, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[1]  = '{mk(1,4,0,4,5,1,1,'h0002,'h0006,0),    3, 16'h4495, 16'h0002, 16'h0006, 2'd1, 2'd2};
        tab[2]  = '{mk(1,4,0,0,5,3,0,'h1234,'h2222,0),    2, 16'h4035, 16'h1234, 16'h0,    2'd1, 2'd0};
`ifdef INSTR_ENC_CG_EN
        tab[3]  = '{mk(1,4,0,0,5,3,0,'h0001,'h2222,0),    1, 16'h4315, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[12] = '{mk(1,4,1,0,5,3,0,'h00FF,'h2222,0),    1, 16'h4375, 16'h0,    16'h0,    2'd0, 2'd0};
`else
        tab[3]  = '{mk(1,4,0,0,5,3,0,'h0001,'h2222,0),    2, 16'h4035, 16'h0001, 16'h0,    2'd1, 2'd0};
        tab[12] = '{mk(1,4,1,0,5,3,0,'h00FF,'h2222,0),    2, 16'h4075, 16'h00FF, 16'h0,    2'd1, 2'd0};
`endif
        tab[4]  = '{mk(2,4,0,0,4,0,0,'h1111,'h2222,0),    1, 16'h1204, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[5]  = '{mk(1,4,0,2,5,1,0,'h0200,'h2222,0),    2, 16'h4215, 16'h0200, 16'h0,    2'd1, 2'd0};
        tab[6]  = '{mk(1,5,0,3,6,2,0,'h1111,'h2222,0),    1, 16'h5326, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[7]  = '{mk(1,4,1,4,2,0,1,'h3333,'h0100,0),    2, 16'h44C2, 16'h0100, 16'h0,    2'd2, 2'd0};
        tab[8]  = '{mk(3,1,0,0,0,0,0,'h1111,'h2222,'h200),1, 16'h2600, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[9]  = '{mk(1,4,0,4,3,0,1,'h1111,'h2222,0),    1, 16'h4483, 16'h0,    16'h0,    2'd0, 2'd0};
        tab[10] = '{mk(2,4,0,0,0,3,0,'h55AA,'h2222,0),    2, 16'h1230, 16'h55AA, 16'h0,    2'd1, 2'd0};
        tab[11] = '{mk(1,4,0,2,5,3,0,'h9999,'h2222,0),    1, 16'h4235, 16'h0,    16'h0,    2'd0, 2'd0};

        // Reset state
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_mdb_out", 32'(MDB_out), 32'd0);
        chk("rst_mdb_valid", 32'(mdb_valid), 32'd0);
        chk("rst_word_idx", 32'(word_idx), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1 chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed vector table
        for (int k = 0; k < 13; k++) begin
            push_exp(int'(tab[k].w0), 0);
            if (tab[k].n > 1) push_exp(int'(tab[k].w1), int'(tab[k].i1));
            if (tab[k].n > 2) push_exp(int'(tab[k].w2), int'(tab[k].i2));
            send(tab[k].r, 1'b1, c);
            drain();
        end

        // Back-to-back: JMP then MOV with no bubble
        push_exp('h3FFF, 0);
        push_exp('h4405, 0);
        send(mk(3,7,0,0,0,0,0,0,0,'h3FF), 1'b1, c);
        send(mk(1,4,0,4,5,0,0,0,0,0), 1'b1, c);
        chk("no_bubble_cycles", 32'(c), 32'd1);
        chk("no_bubble_word", 32'(MDB_out), 32'h4405);
        drain();

        // Stall on the src ext word
        push_exp('h4035, 0);
        push_exp('h1234, 1);
        send(mk(1,4,0,0,5,3,0,'h1234,'h2222,0), 1'b1, c);
        tick();
        mdb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_word", 32'(MDB_out), 32'h1234);
            chk("stall_idx", 32'(word_idx), 32'd1);
            chk("stall_valid", 32'(mdb_valid), 32'd1);
        end
        mdb_ready = 1'b1;
        drain();

        // Invalid requests
        send(mk(0,4,0,4,5,0,0,0,0,0), 1'b0, c);
        chk("err_fmt0_set", 32'(err), 32'd1);
        chk("err_fmt0_novalid", 32'(mdb_valid), 32'd0);
        tick();
        chk("err_fmt0_clear", 32'(err), 32'd0);
        chk("err_fmt0_idle", 32'(mdb_valid), 32'd0);
        send(mk(1,3,0,4,5,0,0,0,0,0), 1'b0, c);
        chk("err_op3_set", 32'(err), 32'd1);
        chk("err_op3_novalid", 32'(mdb_valid), 32'd0);
        tick();

        // Reset mid-stream
        mdb_ready = 1'b0;
        push_exp('h4495, 0);
        send(mk(1,4,0,4,5,1,1,'h0002,'h0006,0), 1'b1, c);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(mdb_valid), 32'd0);
        chk("midrst_mdb_out", 32'(MDB_out), 32'd0);
        expq.delete();
        tick();
        rst = 1'b0;
        mdb_ready = 1'b1;
        #1 chk("midrst_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrst_no_stale", 32'(mdb_valid), 32'd0);
        end

        // Randomized traffic against the reference model
        auto_push = 1'b1;
        rnd_rdy = 1'b1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
            end
            send(rnd_req(), 1'b0, c);
        end
        drain();
        rnd_rdy = 1'b0;
        mdb_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
